div_unit: RTL and testbench

Multi-cycle 32-bit integer divider that serves DIV/DIVU requests issued by the EX stage. EX raises a start request with two operands. The unit runs a radix-2 restoring division, then returns {remainder, quotient}; EX forwards these as hi_o/lo_o with whilo_o set. The pipeline stall controller holds the front end while EX waits on ready_o.

---
 rtl/div_unit.sv | 124 ++++++++++++
 tb/tb_div_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
// Define DIV_BYZERO_FAST_EN to short-circuit a zero divisor to a 1-cycle zero result.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  // state  | meaning
  // FREE   | idle, waiting for start_i
  // BYZERO | zero divisor, fast zero result (DIV_BYZERO_FAST_EN only)
  // ON     | iterating, cnt counts completed iterations
  // FINISH | result valid, held until start_i drops
`ifdef DIV_BYZERO_FAST_EN
  typedef enum logic [1:0] {FREE = 2'd0, BYZERO = 2'd1, ON = 2'd2, FINISH = 2'd3} state_t;
`else
  typedef enum logic [1:0] {FREE = 2'd0, ON = 2'd2, FINISH = 2'd3} state_t;
`endif

  state_t      state;
  logic [5:0]  cnt;
  logic [64:0] work;
  logic [31:0] dv_abs;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] dd_abs_in;
  logic [31:0] dv_abs_in;
  logic [32:0] diff;
  logic [31:0] q_raw;
  logic [31:0] r_raw;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign dd_abs_in = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign dv_abs_in = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  assign diff  = work[64:32] - {1'b0, dv_abs};
  assign q_raw = work[31:0];
  assign r_raw = work[64:33];
  assign q_fix = neg_q ? (~q_raw + 32'd1) : q_raw;
  assign r_fix = neg_r ? (~r_raw + 32'd1) : r_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      work     <= 65'd0;
      dv_abs   <= 32'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i && !annul_i) begin
`ifdef DIV_BYZERO_FAST_EN
            if (opdata2_i == 32'd0) begin
              state <= BYZERO;
            end else begin
`else
            begin
`endif
              // Without the fast path a zero divisor simply runs the full iteration.
              work   <= {32'd0, dd_abs_in, 1'b0};
              dv_abs <= dv_abs_in;
              neg_q  <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
              neg_r  <= signed_div_i && opdata1_i[31];
              cnt    <= 6'd0;
              state  <= ON;
            end
          end
        end
`ifdef DIV_BYZERO_FAST_EN
        BYZERO: begin
          result_o <= 64'd0;
          ready_o  <= 1'b1;
          state    <= FINISH;
        end
`endif
        ON: begin
          if (annul_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end else if (cnt != 6'd32) begin
            if (diff[32]) begin
              work <= {work[63:0], 1'b0};
            end else begin
              work <= {diff[31:0], work[31:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
            state    <= FINISH;
          end
        end
        FINISH: begin
          if (!start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end
        default: begin
          state    <= FREE;
          ready_o  <= 1'b0;
          result_o <= 64'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; expectations follow DIV_BYZERO_FAST_EN.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a request and count cycles from acceptance until ready_o; start_i is left high.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int lat, output logic [63:0] res);
    @(negedge clk);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready_o) break;
    end
    if (!ready_o) lat = 999;
    res = result_o;
  endtask

  task automatic drop_start();
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b result=%h, want ready=0 result=0", ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_divu();
    int lat;
    logic [63:0] res;
    run_div(32'd100, 32'd7, 1'b0, lat, res);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL divu_latency: got %0d, want 33", lat);
    end
    checks++;
    if (res !== {32'h2, 32'hE}) begin
      errors++;
      $display("FAIL divu_100_7: got %h, want %h", res, {32'h2, 32'hE});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b1 || result_o !== {32'h2, 32'hE}) begin
      errors++;
      $display("FAIL divu_hold: ready=%b result=%h, want ready=1 result=%h", ready_o, result_o, {32'h2, 32'hE});
    end
    drop_start();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL divu_release: ready=%b result=%h, want ready=0 result=0", ready_o, result_o);
    end
    run_div(32'hFFFFFFFF, 32'h10, 1'b0, lat, res);
    checks++;
    if (res !== {32'hF, 32'h0FFFFFFF} || lat !== 33) begin
      errors++;
      $display("FAIL divu_max_16: got %h lat %0d, want %h lat 33", res, lat, {32'hF, 32'h0FFFFFFF});
    end
    drop_start();
  endtask

  task automatic test_signed();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [63:0] ve [3];
    int lat;
    logic [63:0] res;
    va[0] = 32'hFFFFFFF9; vb[0] = 32'h2;        ve[0] = {32'hFFFFFFFF, 32'hFFFFFFFD};
    va[1] = 32'h80000000; vb[1] = 32'hFFFFFFFF; ve[1] = {32'h0, 32'h80000000};
    va[2] = 32'h7;        vb[2] = 32'hFFFFFFFE; ve[2] = {32'h1, 32'hFFFFFFFD};
    for (int i = 0; i < 3; i++) begin
      run_div(va[i], vb[i], 1'b1, lat, res);
      checks++;
      if (res !== ve[i] || lat !== 33) begin
        errors++;
        $display("FAIL div_signed_%0d: got %h lat %0d, want %h lat 33", i, res, lat, ve[i]);
      end
      drop_start();
    end
  endtask

  task automatic test_byzero();
    int lat;
    logic [63:0] res;
    int exp_lat;
    logic [63:0] exp_res;
`ifdef DIV_BYZERO_FAST_EN
    exp_lat = 1;  exp_res = 64'd0;
`else
    exp_lat = 33; exp_res = {32'h00001234, 32'hFFFFFFFF};
`endif
    run_div(32'h1234, 32'h0, 1'b0, lat, res);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL byzero_latency: got %0d, want %0d", lat, exp_lat);
    end
    checks++;
    if (res !== exp_res) begin
      errors++;
      $display("FAIL byzero_result: got %h, want %h", res, exp_res);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL byzero_ready: got %b, want 1", ready_o);
    end
    drop_start();
  endtask

  task automatic test_annul();
    int lat;
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    opdata1_i = 32'd50; opdata2_i = 32'd5; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      if (k == 10) begin
        @(negedge clk);
        annul_i = 1'b1;
      end
      @(posedge clk);
      #1;
      if (ready_o) seen = 1'b1;
    end
    @(negedge clk);
    annul_i   = 1'b0;
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    @(posedge clk);
    #1;
    if (ready_o) seen = 1'b1;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL annul_no_ready: ready rose for annulled request");
    end
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready_o) break;
    end
    checks++;
    if (lat !== 33 || result_o !== {32'h0, 32'h3}) begin
      errors++;
      $display("FAIL annul_restart: got %h lat %0d, want %h lat 33", result_o, lat, {32'h0, 32'h3});
    end
    drop_start();
  endtask

  task automatic test_operand_change();
    int lat;
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd10; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'b1;
    lat = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++) begin
      if (ready_o) break;
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 33 || result_o !== {32'h0, 32'd100}) begin
      errors++;
      $display("FAIL operand_change: got %h lat %0d, want %h lat 33", result_o, lat, {32'h0, 32'd100});
    end
    drop_start();
  endtask

  task automatic test_rst_mid();
    int lat;
    logic [63:0] res;
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd10; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL rst_in_on: ready=%b result=%h, want 0/0", ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    run_div(32'd77, 32'd7, 1'b0, lat, res);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL rst_in_end: ready=%b result=%h, want 0/0", ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    run_div(32'd8, 32'd2, 1'b0, lat, res);
    checks++;
    if (lat !== 33 || res !== {32'h0, 32'h4}) begin
      errors++;
      $display("FAIL rst_then_8_2: got %h lat %0d, want %h lat 33", res, lat, {32'h0, 32'h4});
    end
    drop_start();
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_byzero();
    test_annul();
    test_operand_change();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
